// File: rtl/lsu_byte_master.sv
// lsu_byte_master: byte-serial big-endian load/store initiator; `define MISALIGN_CHECK_EN to reject misaligned h/w accesses
module lsu_byte_master #(
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [31:0]       resp_rdata,
    output logic              resp_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    input  logic [7:0]        mem_rdata,
    input  logic              mem_ack
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state, w_next;
    logic              r_we, r_err;
    logic [2:0]        r_f3;
    logic [ADDR_W-1:0] r_addr;
    logic [1:0]        r_idx, r_last;
    logic [31:0]       r_sh, r_acc;
    logic              w_accept, w_legal, w_misal, w_err, w_step;
    logic [1:0]        w_last;
    logic [31:0]       w_sh, w_ext;

    assign w_accept = req_valid && req_ready;
    assign w_step   = mem_req && mem_ack;
    assign w_legal  = (req_funct3 inside {3'b000, 3'b001, 3'b010}) ||
                      (!req_we && (req_funct3 inside {3'b100, 3'b101}));
`ifdef MISALIGN_CHECK_EN
    assign w_misal  = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                      (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign w_misal  = 1'b0;
`endif
    assign w_err    = !w_legal || w_misal;
    assign w_last   = req_funct3[1:0] == 2'b00 ? 2'd0 : req_funct3[1:0] == 2'b01 ? 2'd1 : 2'd3;
    // store bytes are pre-aligned to the top so the outgoing byte is always r_sh[31:24]
    assign w_sh     = req_funct3[1:0] == 2'b00 ? {req_wdata[7:0], 24'h0} :
                      req_funct3[1:0] == 2'b01 ? {req_wdata[15:0], 16'h0} : req_wdata;
    assign w_ext    = r_f3 == 3'b000 ? {{24{r_acc[7]}}, r_acc[7:0]} :
                      r_f3 == 3'b001 ? {{16{r_acc[15]}}, r_acc[15:0]} :
                      r_f3 == 3'b100 ? {24'h0, r_acc[7:0]} :
                      r_f3 == 3'b101 ? {16'h0, r_acc[15:0]} : r_acc;

    // state register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // next state and handshake outputs
    always_comb begin
        w_next     = r_state;
        req_ready  = r_state == IDLE;
        mem_req    = r_state == ACCESS;
        resp_valid = r_state == RESP;
        if (w_accept) w_next = w_err ? RESP : ACCESS;
        if (w_step && r_idx == r_last) w_next = RESP;
        if (resp_valid && resp_ready) w_next = IDLE;
    end

    // request latch, byte sequencing and load assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_we   <= 1'b0;
            r_err  <= 1'b0;
            r_f3   <= 3'b0;
            r_addr <= '0;
            r_idx  <= 2'd0;
            r_last <= 2'd0;
            r_sh   <= 32'h0;
            r_acc  <= 32'h0;
        end else begin
            if (w_accept) begin
                r_we   <= req_we;
                r_err  <= w_err;
                r_f3   <= req_funct3;
                r_addr <= req_addr;
                r_idx  <= 2'd0;
                r_last <= w_last;
                r_sh   <= w_sh;
                r_acc  <= 32'h0;
            end
            if (w_step) begin
                r_idx <= r_idx + 2'd1;
                r_sh  <= {r_sh[23:0], 8'h00};
                if (!r_we) r_acc <= {r_acc[23:0], mem_rdata};
            end
        end
    end

    assign mem_we     = mem_req && r_we;
    assign mem_addr   = r_addr + ADDR_W'(r_idx);
    assign mem_wdata  = r_sh[31:24];
    assign resp_err   = resp_valid && r_err;
    assign resp_rdata = (resp_valid && !r_we && !r_err) ? w_ext : 32'h0;
endmodule

// File: tb/tb_lsu_byte_master.sv
// tb_lsu_byte_master: directed self-checking bench for lsu_byte_master
module tb_lsu_byte_master;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b1;
    logic [2:0]    req_funct3 = 3'b0;
    logic [AW-1:0] req_addr = '0;
    logic [31:0]   req_wdata = 32'h0;
    logic          req_ready, resp_valid, resp_err, mem_req, mem_we, mem_ack;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata, mem_rdata;

    logic [7:0]    mem [64];
    logic [AW-1:0] lg_addr [256];
    logic [7:0]    lg_data [256];
    logic          lg_we [256];
    int            n_log = 0;
    int            cnt = 0;
    int            stall = 0;
    int            checks = 0, errors = 0;
    int            lat, base;

    lsu_byte_master #(.ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    assign mem_ack   = mem_req && (cnt >= stall);

    always @(posedge clk) begin
        cnt <= (!mem_req || mem_ack) ? 0 : cnt + 1;
        if (mem_req && mem_ack) begin
            lg_addr[n_log[7:0]] <= mem_addr;
            lg_data[n_log[7:0]] <= mem_wdata;
            lg_we[n_log[7:0]]   <= mem_we;
            n_log <= n_log + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [AW-1:0] a, input logic [31:0] wd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_resp(output int l);
        l = 1;
        while (!resp_valid && l < 200) begin
            @(posedge clk); #1;
            l++;
        end
        if (l >= 200) chk("resp_timeout", 32'(resp_valid), 32'd1);
    endtask

    task automatic take_resp();
        chk("no_ready_in_resp", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        chk("idle_after_resp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'h00;
        mem[0] = 8'd17; mem[1] = 8'd9; mem[2] = 8'd25; mem[3] = 8'd0;
        mem[4] = 8'h80; mem[5] = 8'h01; mem[63] = 8'hFE;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_rdata", resp_rdata, 32'h0);
        chk("rst_err", 32'(resp_err), 32'd0);
        rst = 1'b0;

        base = n_log;
        do_req(1'b0, 3'b010, 6'd0, 32'h0);
        chk("lw_mem_req_t1", 32'(mem_req), 32'd1);
        wait_resp(lat);
        chk("lw_latency", 32'(lat), 32'd5);
        chk("lw_rdata", resp_rdata, 32'h11091900);
        chk("lw_err", 32'(resp_err), 32'd0);
        take_resp();
        chk("lw_nacc", 32'(n_log - base), 32'd4);
        for (int i = 0; i < 4; i++) chk("lw_addr", 32'(lg_addr[base + i]), 32'(i));

        base = n_log;
        do_req(1'b1, 3'b010, 6'd8, 32'hDEADBEEF);
        wait_resp(lat);
        chk("sw_rdata", resp_rdata, 32'h0);
        chk("sw_err", 32'(resp_err), 32'd0);
        take_resp();
        chk("sw_nacc", 32'(n_log - base), 32'd4);
        chk("sw_b0", {lg_we[base], lg_addr[base], lg_data[base]}, {1'b1, 6'd8, 8'hDE});
        chk("sw_b1", {lg_we[base+1], lg_addr[base+1], lg_data[base+1]}, {1'b1, 6'd9, 8'hAD});
        chk("sw_b2", {lg_we[base+2], lg_addr[base+2], lg_data[base+2]}, {1'b1, 6'd10, 8'hBE});
        chk("sw_b3", {lg_we[base+3], lg_addr[base+3], lg_data[base+3]}, {1'b1, 6'd11, 8'hEF});

        base = n_log;
        do_req(1'b1, 3'b001, 6'd20, 32'h12345678);
        wait_resp(lat);
        chk("sh_latency", 32'(lat), 32'd3);
        take_resp();
        chk("sh_b0", {lg_addr[base], lg_data[base]}, {6'd20, 8'h56});
        chk("sh_b1", {lg_addr[base+1], lg_data[base+1]}, {6'd21, 8'h78});

        do_req(1'b0, 3'b000, 6'd4, 32'h0);
        wait_resp(lat);
        chk("lb_latency", 32'(lat), 32'd2);
        chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
        take_resp();
        do_req(1'b0, 3'b100, 6'd4, 32'h0);
        wait_resp(lat);
        chk("lbu_rdata", resp_rdata, 32'h00000080);
        take_resp();
        do_req(1'b0, 3'b001, 6'd4, 32'h0);
        wait_resp(lat);
        chk("lh_rdata", resp_rdata, 32'hFFFF8001);
        take_resp();
        do_req(1'b0, 3'b101, 6'd4, 32'h0);
        wait_resp(lat);
        chk("lhu_rdata", resp_rdata, 32'h00008001);
        take_resp();

        stall = 3;
        resp_ready = 1'b0;
        begin
            int ea, bad, rc;
            ea = 0; bad = 0; rc = 0;
            do_req(1'b0, 3'b010, 6'd0, 32'h0);
            for (int c = 0; c < 100 && !resp_valid; c++) begin
                if (mem_req) begin
                    rc++;
                    if (mem_addr !== ea[AW-1:0]) bad++;
                    if (mem_ack) ea++;
                end
                @(posedge clk); #1;
            end
            chk("stall_req_cycles", 32'(rc), 32'd16);
            chk("stall_addr_hold", 32'(bad), 32'd0);
        end
        for (int k = 0; k < 3; k++) begin
            chk("stall_resp_valid", 32'(resp_valid), 32'd1);
            chk("stall_resp_rdata", resp_rdata, 32'h11091900);
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        stall = 0;
        take_resp();
        chk("stall_single_resp", 32'(resp_valid), 32'd0);

        stall = 1;
        base = n_log;
        do_req(1'b1, 3'b010, 6'd16, 32'hA1B2C3D4);
        for (int c = 0; c < 50 && !(mem_req && mem_addr == 6'd18 && !mem_ack); c++) begin
            @(posedge clk); #1;
        end
        chk("abort_reach_byte2", {31'(mem_addr), mem_req}, {31'd18, 1'b1});
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_mem_req", 32'(mem_req), 32'd0);
        chk("abort_resp_valid", 32'(resp_valid), 32'd0);
        chk("abort_ready", 32'(req_ready), 32'd1);
        chk("abort_rdata", resp_rdata, 32'h0);
        stall = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_resp", 32'(resp_valid), 32'd0);
        chk("abort_nwrites", 32'(n_log - base), 32'd2);
        chk("abort_b0", {lg_addr[base], lg_data[base]}, {6'd16, 8'hA1});
        chk("abort_b1", {lg_addr[base+1], lg_data[base+1]}, {6'd17, 8'hB2});

        base = n_log;
        do_req(1'b0, 3'b001, 6'h3F, 32'h0);
        wait_resp(lat);
`ifdef MISALIGN_CHECK_EN
        chk("mis_err", 32'(resp_err), 32'd1);
        chk("mis_rdata", resp_rdata, 32'h0);
        chk("mis_latency", 32'(lat), 32'd1);
        take_resp();
        chk("mis_nacc", 32'(n_log - base), 32'd0);
`else
        chk("wrap_err", 32'(resp_err), 32'd0);
        chk("wrap_rdata", resp_rdata, 32'hFFFFFE11);
        take_resp();
        chk("wrap_nacc", 32'(n_log - base), 32'd2);
        chk("wrap_a0", 32'(lg_addr[base]), 32'h3F);
        chk("wrap_a1", 32'(lg_addr[base+1]), 32'h00);
`endif

        base = n_log;
        do_req(1'b0, 3'b011, 6'd0, 32'h0);
        wait_resp(lat);
        chk("f011_latency", 32'(lat), 32'd1);
        chk("f011_err", 32'(resp_err), 32'd1);
        chk("f011_rdata", resp_rdata, 32'h0);
        take_resp();
        do_req(1'b1, 3'b100, 6'd0, 32'hFF);
        wait_resp(lat);
        chk("sbu_err", 32'(resp_err), 32'd1);
        take_resp();
        do_req(1'b0, 3'b110, 6'd0, 32'h0);
        wait_resp(lat);
        chk("f110_err", 32'(resp_err), 32'd1);
        take_resp();
        chk("illegal_nacc", 32'(n_log - base), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
